// File: rtl/binary_to_bcd_converter.sv
// binary_to_bcd_converter: iterative double-dabble, unsigned binary in, packed BCD out.
// Result and overflow are held between conversions so a downstream display never
// shows intermediate values.
//
// Ports:
//   clock     in   rising-edge system clock
//   reset_n   in   asynchronous active-low reset
//   binary_in in   [BINARY_WIDTH-1:0] value, sampled when start is accepted
//   start     in   conversion request, accepted only while ready=1
//   ready     out  high in IDLE only
//   done      out  one-cycle pulse in the cycle bcd_out/overflow become valid
//   bcd_out   out  [4*DIGITS-1:0] packed BCD, digit 0 in [3:0]
//   overflow  out  last accepted value exceeded 10^DIGITS-1
//
// Build option: define BIN2BCD_SATURATE_EN to show an over-range value as all 9s;
// without it an over-range value is shown as all 4'hE.

module binary_to_bcd_converter #(
    parameter int BINARY_WIDTH = 14,
    parameter int DIGITS       = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [BINARY_WIDTH-1:0] binary_in,
    input  logic                    start,
    output logic                    ready,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic                    overflow
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BINARY_WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_VALUE = pow10(DIGITS) - 1;

`ifdef BIN2BCD_SATURATE_EN
    localparam logic [SW-1:0] OVF_PATTERN = {DIGITS{4'h9}};
`else
    localparam logic [SW-1:0] OVF_PATTERN = {DIGITS{4'hE}};
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]              r_state;
    logic [SW-1:0]           r_scratch;
    logic [BINARY_WIDTH-1:0] r_shift;
    logic [CW-1:0]           r_cnt;
    logic                    r_over;
    logic [SW-1:0]           r_bcd;
    logic                    r_overflow;

    logic                         w_over;
    logic [SW-1:0]                w_corr;
    logic [SW+BINARY_WIDTH-1:0]   w_cat;
    logic [SW+BINARY_WIDTH-1:0]   w_shifted;
    logic [SW-1:0]                w_next_scratch;

    // Compared at 64 bits so MAX_VALUE may exceed the input range.
    assign w_over = 64'(binary_in) > MAX_VALUE;

    // Add-3 on every digit >= 5, each digit independent (no inter-digit carry).
    always_comb begin
        w_corr = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_corr[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // Top scratch bit falls off; that only happens for over-range inputs.
    assign w_cat          = {w_corr, r_shift};
    assign w_shifted      = w_cat << 1;
    assign w_next_scratch = w_shifted[SW+BINARY_WIDTH-1:BINARY_WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_scratch  <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_over     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift   <= binary_in;
                        r_scratch <= '0;
                        r_cnt     <= CW'(BINARY_WIDTH);
                        r_over    <= w_over;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= w_shifted[BINARY_WIDTH-1:0];
                    r_cnt     <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        // Publish on the final shift so the result is
                        // visible during the DONE cycle itself.
                        r_bcd      <= r_over ? OVF_PATTERN : w_next_scratch;
                        r_overflow <= r_over;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready    = (r_state == ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign bcd_out  = r_bcd;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// tb_binary_to_bcd_converter: randomized and directed checks of the
// double-dabble converter against a decimal-arithmetic reference model.

module tb_binary_to_bcd_converter;

    logic        clock;
    logic        reset_n;
    logic [13:0] binary_in;
    logic        start;
    logic        ready;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int n_cmp;
    int n_err;

    binary_to_bcd_converter #(
        .BINARY_WIDTH(14),
        .DIGITS(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .binary_in(binary_in),
        .start(start),
        .ready(ready),
        .done(done),
        .bcd_out(bcd_out),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int t;
        if (v > 9999) begin
`ifdef BIN2BCD_SATURATE_EN
            return 16'h9999;
`else
            return 16'hEEEE;
`endif
        end
        r = '0;
        t = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Start pulse accepted at edge N; returns k where done is seen in cycle N+k.
    task automatic convert(input int v, output logic [15:0] b,
                           output logic ov, output int lat);
        @(negedge clock);
        binary_in = 14'(v);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        binary_in = 14'($urandom);
        lat = -1;
        b = 'x;
        ov = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (done) begin
                lat = k;
                b = bcd_out;
                ov = overflow;
                break;
            end
        end
    endtask

    task automatic conv_check(input string tag, input int v);
        logic [15:0] b;
        logic ov;
        int lat;
        convert(v, b, ov, lat);
        check({tag, " latency"}, 32'(lat), 32'd15);
        check({tag, " bcd"}, {16'd0, b}, {16'd0, ref_bcd(v)});
        check({tag, " ovf"}, {31'd0, ov}, {31'd0, v > 9999});
    endtask

    initial begin
        logic [15:0] b;
        logic ov;
        int lat;
        int dq[$];
        int k_done;
        int n_done;

        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        start = 1'b0;
        binary_in = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (i % 10 == 0 || i == 99) begin
                check("idle hold", {13'd0, ready, done, overflow, bcd_out},
                      {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
            end
        end

        // Detailed timing for 1234.
        @(negedge clock);
        binary_in = 14'd1234;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check($sformatf("ready N+%0d", k), {31'd0, ready},
                  {31'd0, k == 16});
            check($sformatf("done N+%0d", k), {31'd0, done},
                  {31'd0, k == 15});
            if (k == 15) begin
                check("1234 bcd", {16'd0, bcd_out}, 32'h1234);
                check("1234 ovf", {31'd0, overflow}, 32'd0);
            end
        end

        conv_check("zero", 0);
        conv_check("nine", 9);
        conv_check("ten", 10);
        conv_check("max", 9999);
        conv_check("ovf 10000", 10000);
        conv_check("ovf 16383", 16383);
        conv_check("after ovf", 42);

        // Busy: second start at N+5 must be ignored and not queued.
        @(negedge clock);
        binary_in = 14'd1234;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        k_done = -1;
        n_done = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clock);
            if (done) begin
                n_done++;
                k_done = k;
                check("busy bcd", {16'd0, bcd_out}, 32'h1234);
            end
            if (k <= 14 && (k == 1 || k == 7 || k == 14)) begin
                check($sformatf("busy hold N+%0d", k), {16'd0, bcd_out},
                      32'h0042);
            end
            if (k == 5) begin
                binary_in = 14'd5678;
                start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
            end
        end
        check("busy done cycle", 32'(k_done), 32'd15);
        check("busy done count", 32'(n_done), 32'd1);

        // Start held high: one conversion per 16 cycles.
        @(negedge clock);
        binary_in = 14'd7;
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (done) begin
                dq.push_back(k);
                check("held bcd", {16'd0, bcd_out}, 32'h0007);
            end
        end
        start = 1'b0;
        check("held count", 32'(dq.size()), 32'd3);
        for (int i = 1; i < dq.size(); i++) begin
            check("held period", 32'(dq[i] - dq[i-1]), 32'd16);
        end
        repeat (20) @(negedge clock);

        // Reset mid-conversion of 4321.
        @(negedge clock);
        binary_in = 14'd4321;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst out", {13'd0, ready, done, overflow, bcd_out},
              {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        @(negedge clock);
        reset_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("midrst no done", 32'(n_done), 32'd0);
        check("midrst ready", {31'd0, ready}, 32'd1);
        conv_check("after rst", 4321);

        // Randomized values across the full input range.
        for (int i = 0; i < 1500; i++) begin
            int v;
            if (i % 3 == 0) v = int'($urandom_range(0, 16383));
            else v = int'($urandom_range(0, 9999));
            convert(v, b, ov, lat);
            check($sformatf("rnd %0d lat", v), 32'(lat), 32'd15);
            check($sformatf("rnd %0d bcd", v), {16'd0, b},
                  {16'd0, ref_bcd(v)});
            check($sformatf("rnd %0d ovf", v), {31'd0, ov},
                  {31'd0, v > 9999});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
